// File: rtl/corexy_step_decoder.sv
// corexy_step_decoder: receive side of the CoreXY step/dir link.
// Tracks signed motor A/B positions, derives X = (A+B)/2 and Y = (A-B)/2,
// measures step periods, flags dir-setup violations and reports move end.
// Optional macro STEP_GLITCH_FILTER_EN: a step edge counts only after the
// synchronized step has stayed high for MIN_HIGH consecutive cycles.
//
// state  | meaning
// IDLE   | no recent step activity
// MOVING | an edge was seen within the last IDLE_CYCLES cycles
// DONE   | single cycle, move_done asserted
module corexy_step_decoder #(
  parameter int PERIOD_W    = 24,
  parameter int IDLE_CYCLES = 1000,
  parameter int DIR_SETUP   = 4,
  parameter int MIN_HIGH    = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 step_1,
  input  logic                 dir_1,
  input  logic                 step_2,
  input  logic                 dir_2,
  input  logic                 clear,
  output logic signed [31:0]   pos_a,
  output logic signed [31:0]   pos_b,
  output logic signed [31:0]   pos_x,
  output logic signed [31:0]   pos_y,
  output logic                 half_x,
  output logic [PERIOD_W-1:0]  period_1,
  output logic [PERIOD_W-1:0]  period_2,
  output logic [1:0]           period_valid,
  output logic                 moving,
  output logic                 move_done,
  output logic [1:0]           dir_err
);

  if (MIN_HIGH < 1 || DIR_SETUP < 1 || IDLE_CYCLES < 1 || PERIOD_W < 2) begin : g_bad_param
    $error("corexy_step_decoder: MIN_HIGH, DIR_SETUP, IDLE_CYCLES must be >= 1, PERIOD_W >= 2");
  end

  localparam int IDLE_W = $clog2(IDLE_CYCLES + 1);
  localparam int DSET_W = $clog2(DIR_SETUP + 1);
  localparam logic [IDLE_W-1:0]   IDLE_RELOAD = IDLE_W'(IDLE_CYCLES - 1);
  localparam logic [DSET_W-1:0]   DSET_MAX    = DSET_W'(DIR_SETUP);
  localparam logic [PERIOD_W-1:0] PER_MAX     = '1;

  typedef enum logic [1:0] {IDLE, MOVING, DONE} state_t;

  logic [1:0] step_s1, step_s2, dir_s1, dir_s2, dir_d;
  logic [1:0] step_edge, dir_chg, setup_bad;
  logic [DSET_W-1:0]   dset_cnt [2];
  logic [PERIOD_W-1:0] per_cnt  [2];
  logic [PERIOD_W-1:0] per_q    [2];
  logic [1:0]          edge_seen;
  logic [32:0]         sum_ab, dif_ab;
  logic [IDLE_W-1:0]   idle_cnt;
  state_t              state;
  logic                any_edge;

  // two-flop synchronizers on step and dir, plus a dir history tap for change detect
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step_s1 <= '0;
      step_s2 <= '0;
      dir_s1  <= '0;
      dir_s2  <= '0;
      dir_d   <= '0;
    end else begin
      step_s1 <= {step_2, step_1};
      step_s2 <= step_s1;
      dir_s1  <= {dir_2, dir_1};
      dir_s2  <= dir_s1;
      dir_d   <= dir_s2;
    end
  end

`ifdef STEP_GLITCH_FILTER_EN
  localparam int HI_W = $clog2(MIN_HIGH + 1);
  localparam logic [HI_W-1:0] HI_ARM = HI_W'(MIN_HIGH - 1);
  localparam logic [HI_W-1:0] HI_MAX = HI_W'(MIN_HIGH);
  logic [HI_W-1:0] hi_cnt [2];

  // length of the current high run on each synchronized step, saturating
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_cnt[0] <= '0;
      hi_cnt[1] <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (!step_s2[i])
          hi_cnt[i] <= '0;
        else if (hi_cnt[i] != HI_MAX)
          hi_cnt[i] <= hi_cnt[i] + HI_W'(1);
      end
    end
  end

  // an edge fires once, on the cycle the high run reaches MIN_HIGH
  always_comb begin
    step_edge = '0;
    for (int i = 0; i < 2; i++)
      step_edge[i] = step_s2[i] && (hi_cnt[i] == HI_ARM);
  end
`else
  logic [1:0] step_d;

  // previous synchronized step for rising-edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) step_d <= '0;
    else        step_d <= step_s2;
  end

  assign step_edge = step_s2 & ~step_d;
`endif

  assign dir_chg  = dir_s2 ^ dir_d;
  assign any_edge = (|step_edge) && !clear;

  // the cycle a dir change lands counts as zero stable cycles
  always_comb begin
    setup_bad = '0;
    for (int i = 0; i < 2; i++)
      setup_bad[i] = dir_chg[i] || (dset_cnt[i] < DSET_MAX);
  end

  // cycles since the last synchronized dir change, saturating at DIR_SETUP
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dset_cnt[0] <= '0;
      dset_cnt[1] <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (dir_chg[i])
          dset_cnt[i] <= '0;
        else if (dset_cnt[i] != DSET_MAX)
          dset_cnt[i] <= dset_cnt[i] + DSET_W'(1);
      end
    end
  end

  // motor positions and sticky setup errors; clear drops a coincident edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pos_a   <= '0;
      pos_b   <= '0;
      dir_err <= '0;
    end else if (clear) begin
      pos_a   <= '0;
      pos_b   <= '0;
      dir_err <= '0;
    end else begin
      if (step_edge[0]) pos_a <= dir_s2[0] ? pos_a - 32'sd1 : pos_a + 32'sd1;
      if (step_edge[1]) pos_b <= dir_s2[1] ? pos_b - 32'sd1 : pos_b + 32'sd1;
      dir_err <= dir_err | (step_edge & setup_bad);
    end
  end

  assign sum_ab = {pos_a[31], pos_a} + {pos_b[31], pos_b};
  assign dif_ab = {pos_a[31], pos_a} - {pos_b[31], pos_b};

  // Cartesian view, one cycle behind the motor positions
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pos_x  <= '0;
      pos_y  <= '0;
      half_x <= 1'b0;
    end else begin
      pos_x  <= sum_ab[32:1];
      pos_y  <= dif_ab[32:1];
      half_x <= sum_ab[0];
    end
  end

  // per-motor period measurement: free-running saturating count, sampled and reloaded on each edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      per_cnt[0]   <= '0;
      per_cnt[1]   <= '0;
      per_q[0]     <= '0;
      per_q[1]     <= '0;
      edge_seen    <= '0;
      period_valid <= '0;
    end else if (clear) begin
      per_cnt[0]   <= '0;
      per_cnt[1]   <= '0;
      per_q[0]     <= '0;
      per_q[1]     <= '0;
      edge_seen    <= '0;
      period_valid <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (step_edge[i]) begin
          per_q[i]     <= per_cnt[i];
          per_cnt[i]   <= PERIOD_W'(1);
          edge_seen[i] <= 1'b1;
          if (edge_seen[i]) period_valid[i] <= 1'b1;
        end else if (per_cnt[i] != PER_MAX) begin
          per_cnt[i] <= per_cnt[i] + PERIOD_W'(1);
        end
      end
    end
  end

  assign period_1 = per_q[0];
  assign period_2 = per_q[1];

  // move tracking: idle down-counter reloads on every edge, terminal count ends the move
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      idle_cnt  <= '0;
      moving    <= 1'b0;
      move_done <= 1'b0;
    end else if (clear) begin
      state     <= IDLE;
      idle_cnt  <= '0;
      moving    <= 1'b0;
      move_done <= 1'b0;
    end else begin
      move_done <= 1'b0;
      case (state)
        IDLE: begin
          if (any_edge) begin
            state    <= MOVING;
            moving   <= 1'b1;
            idle_cnt <= IDLE_RELOAD;
          end
        end
        MOVING: begin
          if (any_edge) begin
            idle_cnt <= IDLE_RELOAD;
          end else if (idle_cnt == '0) begin
            state     <= DONE;
            moving    <= 1'b0;
            move_done <= 1'b1;
          end else begin
            idle_cnt <= idle_cnt - IDLE_W'(1);
          end
        end
        DONE: begin
          if (any_edge) begin
            state    <= MOVING;
            moving   <= 1'b1;
            idle_cnt <= IDLE_RELOAD;
          end else begin
            state <= IDLE;
          end
        end
        default: begin
          state  <= IDLE;
          moving <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_corexy_step_decoder.sv
// Bench for corexy_step_decoder: directed scenarios plus randomized step
// trains, checked against a model that simply counts signed steps and
// remembers when each pulse was launched.
`timescale 1ns/1ps
module tb_corexy_step_decoder;
  localparam int PERIOD_W    = 24;
  localparam int IDLE_CYCLES = 1000;
`ifdef STEP_GLITCH_FILTER_EN
  localparam int LAT = 5;
`else
  localparam int LAT = 3;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic step_1 = 1'b0, dir_1 = 1'b0, step_2 = 1'b0, dir_2 = 1'b0, clear = 1'b0;
  logic signed [31:0] pos_a, pos_b, pos_x, pos_y;
  logic half_x;
  logic [PERIOD_W-1:0] period_1, period_2;
  logic [1:0] period_valid, dir_err;
  logic moving, move_done;

  int checks = 0;
  int failures = 0;
  int done_pulses = 0;
  int cyc = 0;

  // reference model state
  int ma = 0, mb = 0;
  int last_rise[2] = '{0, 0};
  int prev_rise[2] = '{0, 0};
  int nedge[2] = '{0, 0};

  corexy_step_decoder #(.PERIOD_W(PERIOD_W), .IDLE_CYCLES(IDLE_CYCLES), .DIR_SETUP(4), .MIN_HIGH(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .step_1(step_1), .dir_1(dir_1), .step_2(step_2), .dir_2(dir_2),
    .clear(clear),
    .pos_a(pos_a), .pos_b(pos_b), .pos_x(pos_x), .pos_y(pos_y), .half_x(half_x),
    .period_1(period_1), .period_2(period_2), .period_valid(period_valid),
    .moving(moving), .move_done(move_done), .dir_err(dir_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (move_done) done_pulses++;

  initial begin
    #2ms;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic wait_cyc(input int n);
    repeat (n) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_clear();
    clear = 1'b1;
    wait_cyc(1);
    clear = 1'b0;
    wait_cyc(1);
    ma = 0;
    mb = 0;
    nedge = '{0, 0};
  endtask

  task automatic pulse(input bit on1, input bit on2, input bit d1, input bit d2, input int hi, input int lo);
    if ((on1 && dir_1 != d1) || (on2 && dir_2 != d2)) begin
      if (on1) dir_1 = d1;
      if (on2) dir_2 = d2;
      wait_cyc(6);
    end
    if (on1) step_1 = 1'b1;
    if (on2) step_2 = 1'b1;
    for (int m = 0; m < 2; m++) begin
      if ((m == 0) ? on1 : on2) begin
        prev_rise[m] = last_rise[m];
        last_rise[m] = cyc;
        nedge[m]++;
      end
    end
    if (on1) ma += d1 ? -1 : 1;
    if (on2) mb += d2 ? -1 : 1;
    wait_cyc(hi);
    step_1 = 1'b0;
    step_2 = 1'b0;
    wait_cyc(lo);
  endtask

  task automatic check_model(input string tag);
    longint s, d;
    logic [31:0] ex, ey;
    logic [1:0] ev;
    s  = longint'(ma) + longint'(mb);
    d  = longint'(ma) - longint'(mb);
    ex = 32'((s - (s & 1)) / 2);
    ey = 32'((d - (d & 1)) / 2);
    ev = {nedge[1] >= 2, nedge[0] >= 2};
    chk({tag, "_pos_a"}, pos_a, ma);
    chk({tag, "_pos_b"}, pos_b, mb);
    chk({tag, "_pos_x"}, pos_x, ex);
    chk({tag, "_pos_y"}, pos_y, ey);
    chk({tag, "_half_x"}, half_x, 32'(s & 1));
    chk({tag, "_valid"}, period_valid, ev);
    if (nedge[0] >= 2) chk({tag, "_period_1"}, period_1, last_rise[0] - prev_rise[0]);
    if (nedge[1] >= 2) chk({tag, "_period_2"}, period_2, last_rise[1] - prev_rise[1]);
    chk({tag, "_dir_err"}, dir_err, 0);
  endtask

  initial begin
    int n, d0;
    bit on1, on2;

    // reset values
    wait_cyc(3);
    chk("rst_pos_a", pos_a, 0);
    chk("rst_pos_b", pos_b, 0);
    chk("rst_pos_x", pos_x, 0);
    chk("rst_pos_y", pos_y, 0);
    chk("rst_half_x", half_x, 0);
    chk("rst_period_1", period_1, 0);
    chk("rst_period_2", period_2, 0);
    chk("rst_valid", period_valid, 0);
    chk("rst_moving", moving, 0);
    chk("rst_move_done", move_done, 0);
    chk("rst_dir_err", dir_err, 0);
    rst_n = 1'b1;
    wait_cyc(10);

    // ten A pulses, 4 high / 4 low, positive direction
    for (int i = 0; i < 10; i++) pulse(1, 0, 0, 0, 4, 4);
    wait_cyc(LAT + 3);
    chk("t1_pos_a", pos_a, 10);
    chk("t1_pos_x", pos_x, 5);
    chk("t1_pos_y", pos_y, 5);
    chk("t1_half_x", half_x, 0);
    chk("t1_period_1", period_1, 8);
    chk("t1_valid", period_valid, 2'b01);
    chk("t1_moving", moving, 1);
    check_model("t1");

    // simultaneous pulses, A forward and B reverse
    do_clear();
    chk("clr_moving", moving, 0);
    for (int i = 0; i < 3; i++) pulse(1, 1, 0, 1, 4, 4);
    wait_cyc(LAT + 3);
    chk("t2_pos_a", pos_a, 3);
    chk("t2_pos_b", pos_b, 32'hFFFF_FFFD);
    chk("t2_pos_x", pos_x, 0);
    chk("t2_pos_y", pos_y, 3);
    chk("t2_valid", period_valid, 2'b11);
    chk("t2_period_2", period_2, 8);
    check_model("t2");

    // randomized trains on either or both motors
    do_clear();
    for (int i = 0; i < 60; i++) begin
      n = $urandom_range(1, 3);
      on1 = n[0];
      on2 = n[1];
      pulse(on1, on2, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            $urandom_range(3, 5), $urandom_range(2, 6));
      if (i % 15 == 14) begin
        wait_cyc(LAT + 3);
        check_model("rnd");
      end
    end

    // wrap of pos_b from the most positive value
    do_clear();
    force dut.pos_b = 32'h7FFF_FFFF;
    wait_cyc(1);
    release dut.pos_b;
    wait_cyc(2);
    mb = 32'h7FFF_FFFF;
    chk("wrap_preload", pos_b, 32'h7FFF_FFFF);
    pulse(0, 1, 0, 0, 4, 4);
    wait_cyc(LAT + 3);
    chk("wrap_pos_b", pos_b, 32'h8000_0000);
    chk("wrap_pos_x", pos_x, 32'hC000_0000);
    chk("wrap_pos_y", pos_y, 32'h4000_0000);
    check_model("wrap");

    // dir changed only two cycles before the step
    do_clear();
    if (dir_1 != 1'b0) begin
      dir_1 = 1'b0;
      wait_cyc(10);
    end
    dir_1 = 1'b1;
    wait_cyc(2);
    step_1 = 1'b1;
    wait_cyc(4);
    step_1 = 1'b0;
    wait_cyc(LAT + 4);
    chk("setup_dir_err", dir_err, 2'b01);
    chk("setup_pos_a", pos_a, 32'hFFFF_FFFF);
    do_clear();
    chk("setup_clr_err", dir_err, 0);
    chk("setup_clr_pos_a", pos_a, 0);

    // move start latency and move_done timing
    dir_1 = 1'b0;
    wait_cyc(10);
    chk("md_idle", moving, 0);
    d0 = done_pulses;
    step_1 = 1'b1;
    wait_cyc(LAT - 1);
    chk("md_before", moving, 0);
    wait_cyc(1);
    chk("md_rise", moving, 1);
    n = 0;
    while (!move_done && n < IDLE_CYCLES + 50) begin
      wait_cyc(1);
      n++;
      if (n == 1) step_1 = 1'b0;
    end
    chk("md_delay", n, IDLE_CYCLES);
    wait_cyc(1);
    chk("md_pulse_end", move_done, 0);
    chk("md_moving_low", moving, 0);
    chk("md_count", done_pulses - d0, 1);

    // clear mid-move suppresses move_done
    d0 = done_pulses;
    step_1 = 1'b1;
    wait_cyc(5);
    step_1 = 1'b0;
    wait_cyc(100);
    chk("mc_moving", moving, 1);
    do_clear();
    wait_cyc(IDLE_CYCLES + 100);
    chk("mc_no_done", done_pulses - d0, 0);
    chk("mc_moving_low", moving, 0);

`ifdef STEP_GLITCH_FILTER_EN
    // short highs are rejected, MIN_HIGH highs count at 5-cycle latency
    do_clear();
    step_1 = 1'b1;
    wait_cyc(2);
    step_1 = 1'b0;
    wait_cyc(10);
    chk("gf_short", pos_a, 0);
    step_1 = 1'b1;
    wait_cyc(4);
    chk("gf_before", pos_a, 0);
    wait_cyc(1);
    chk("gf_count", pos_a, 1);
    step_1 = 1'b0;
    wait_cyc(10);
`else
    // a one-cycle high is still a valid edge without the filter
    do_clear();
    step_1 = 1'b1;
    wait_cyc(1);
    step_1 = 1'b0;
    wait_cyc(1);
    chk("one_before", pos_a, 0);
    wait_cyc(1);
    chk("one_count", pos_a, 1);
    wait_cyc(10);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
